// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit for the EXE stage.
// Multiplies complete after MUL_STAGES cycles; divides use a radix-2 restoring
// loop of WIDTH iterations; stall_o holds EXE until the done_o cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned MUL_STAGES    = 3,
    parameter int unsigned DIV_EARLY_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned PW           = 2 * WIDTH;
    localparam int unsigned CNT_MAX      = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
    localparam int unsigned CNT_W        = $clog2(CNT_MAX + 1);
    localparam int unsigned MUL_CNT_INIT = (MUL_STAGES > 1) ? (MUL_STAGES - 2) : 0;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [CNT_W-1:0]  cnt;
    logic [PW-1:0]     prod_q;
    logic [WIDTH-1:0]  quo_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  dvs_q;
    logic              neg_q_q;
    logic              neg_r_q;

    logic              accept;
    logic              a_sgn;
    logic              b_sgn;
    logic signed [WIDTH:0] ea;
    logic signed [WIDTH:0] eb;
    logic [PW-1:0]     prod_c;
    logic              b_zero;
    logic              ovf;
    logic              early;
    logic [WIDTH-1:0]  early_res;
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH:0]    shifted;
    logic              fits;
    logic [WIDTH-1:0]  quo_n;
    logic [WIDTH-1:0]  rem_n;
    logic [WIDTH-1:0]  q_fix;
    logic [WIDTH-1:0]  r_fix;
    logic [WIDTH-1:0]  div_res;

    // MUL returns the low half of the product, all other multiplies the high half.
    function automatic logic [WIDTH-1:0] mul_sel(input logic [1:0] op, input logic [PW-1:0] prod);
        return (op == 2'b00) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
    endfunction

    // Accept decode, operand extension, early-out detection and divide setup.
    always_comb begin
        accept    = valid_i & (state == IDLE) & ~flush_i;
        a_sgn     = (op_i[1:0] == 2'b01) | (op_i[1:0] == 2'b10);
        b_sgn     = (op_i[1:0] == 2'b01);
        ea        = {a_sgn & a_i[WIDTH-1], a_i};
        eb        = {b_sgn & b_i[WIDTH-1], b_i};
        prod_c    = PW'(ea) * PW'(eb);
        b_zero    = (b_i == '0);
        ovf       = ~op_i[0] & (a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (b_i == '1);
        early     = op_i[2] & (DIV_EARLY_OUT != 0) & (b_zero | ovf);
        if (op_i[1]) early_res = b_zero ? a_i : '0;
        else         early_res = b_zero ? '1 : a_i;
        a_neg     = ~op_i[0] & a_i[WIDTH-1];
        b_neg     = ~op_i[0] & b_i[WIDTH-1];
        a_mag     = a_neg ? -a_i : a_i;
        b_mag     = b_neg ? -b_i : b_i;
    end

    // One restoring-division step plus the sign fixup applied on the last step.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs_q});
        rem_n   = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
        quo_n   = {quo_q[WIDTH-2:0], fits};
        q_fix   = neg_q_q ? -quo_n : quo_n;
        r_fix   = neg_r_q ? -rem_n : rem_n;
        div_res = op_q[1] ? r_fix : q_fix;
    end

    // Control FSM with operand latches, divider datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            cnt      <= '0;
            prod_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_i[1:0];
                        prod_q  <= prod_c;
                        quo_q   <= a_mag;
                        rem_q   <= '0;
                        dvs_q   <= b_mag;
                        neg_q_q <= (a_neg ^ b_neg) & ~b_zero;
                        neg_r_q <= a_neg;
                        if (op_i[2]) begin
                            if (early) begin
                                result_o <= early_res;
                                done_o   <= 1'b1;
                                state    <= FIN;
                            end else begin
                                cnt   <= CNT_W'(WIDTH - 1);
                                state <= DIV;
                            end
                        end else if (MUL_STAGES == 1) begin
                            result_o <= mul_sel(op_i[1:0], prod_c);
                            done_o   <= 1'b1;
                            state    <= FIN;
                        end else begin
                            cnt   <= CNT_W'(MUL_CNT_INIT);
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        result_o <= mul_sel(op_q, prod_q);
                        done_o   <= 1'b1;
                        state    <= FIN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DIV: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        quo_q <= quo_n;
                        rem_q <= rem_n;
                        if (cnt == '0) begin
                            result_o <= div_res;
                            done_o   <= 1'b1;
                            state    <= FIN;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o  = (state != IDLE);
    assign stall_o = accept | ((state != IDLE) & (state != FIN));

endmodule
